// File: rtl/ifmap_addr_if.sv
// -----------------------------------------------------------------------------
// ifmap_addr_if
//   Beat bus between the ifmap address generator and the ifmap SRAM banks / PE
//   array. One beat = one SRAM word address plus per-beat framing.
//
//   addr_valid     beat valid (generator -> consumer)
//   addr_ready     consumer accepts the current beat (consumer -> generator)
//   address_ifmap  SRAM word address
//   pad_zero       beat lies in the zero-padding border
//   channel_en     active-lane mask, one bit per SRAM bank
//   PE_start       first beat of an output pixel
//   first_channel  beat belongs to channel group 0
//   last_channel   beat belongs to the final channel group
//   pixel_last     final beat of an output pixel
//
//   master: the address generator; slave: the consumer.
// -----------------------------------------------------------------------------
interface ifmap_addr_if #(
  parameter int ADDR_W    = 16,
  parameter int NUM_LANES = 32
);
  logic                 addr_valid;
  logic                 addr_ready;
  logic [ADDR_W-1:0]    address_ifmap;
  logic                 pad_zero;
  logic [NUM_LANES-1:0] channel_en;
  logic                 PE_start;
  logic                 first_channel;
  logic                 last_channel;
  logic                 pixel_last;

  modport master (
    output addr_valid, address_ifmap, pad_zero, channel_en,
           PE_start, first_channel, last_channel, pixel_last,
    input  addr_ready
  );

  modport slave (
    input  addr_valid, address_ifmap, pad_zero, channel_en,
           PE_start, first_channel, last_channel, pixel_last,
    output addr_ready
  );
endinterface

// File: rtl/ifmap_addr_gen.sv
// -----------------------------------------------------------------------------
// ifmap_addr_gen
//   Input-feature-map address generator and PE sequencer for the BNN
//   convolution engine. Walks output pixel (oy, ox), then channel group g,
//   then kernel row ky, then kernel column kx, emitting one ifmap SRAM address
//   per beat on a valid/ready bus.
//
// Ports
//   clk             clock, rising edge
//   rst             synchronous active-low reset
//   start           run request, accepted only in IDLE
//   image_size      square input dimension H      (sampled on accepted start)
//   number_channel  input channel count C
//   kernel_size     square kernel K
//   padding         pad amount P per side
//   stride          stride S, 0 is treated as 1
//   busy            high from accepted start until done
//   done            one-cycle pulse after the final beat is accepted
//   config_err      one-cycle pulse when start is rejected for illegal config
//   beat            ifmap_addr_if master (address beat bus)
//
// Optional feature (macro IFMAP_PERF_CNT_EN)
//   perf_beats      saturating count of accepted beats
//   perf_stalls     saturating count of cycles with addr_valid && !addr_ready
//   Both clear on accepted start and on reset and hold after done.
// -----------------------------------------------------------------------------
module ifmap_addr_gen #(
  parameter int ADDR_W    = 16,
  parameter int DIM_W     = 16,
  parameter int CH_W      = 6,
  parameter int NUM_LANES = 32,
  parameter int K_W       = 4,
  parameter int PAD_W     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  image_size,
  input  logic [CH_W-1:0]   number_channel,
  input  logic [K_W-1:0]    kernel_size,
  input  logic [PAD_W-1:0]  padding,
  input  logic [1:0]        stride,
  output logic              busy,
  output logic              done,
  output logic              config_err,
`ifdef IFMAP_PERF_CNT_EN
  output logic [31:0]       perf_beats,
  output logic [31:0]       perf_stalls,
`endif
  ifmap_addr_if.master      beat
);

  // PW holds the padded extent H+2P plus a stride and kernel step without
  // overflow; SW adds a sign bit for padded coordinates.
  localparam int PW = DIM_W + 2;
  localparam int SW = DIM_W + 3;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_FIN} state_t;

  state_t state_q, state_d;

  // Run configuration
  logic [DIM_W-1:0]     h_r;
  logic [CH_W-1:0]      c_r;
  logic [K_W-1:0]       k_r;
  logic [PAD_W-1:0]     p_r;
  logic [1:0]           s_r;
  logic [PW-1:0]        hp_r;         // H + 2P
  logic [ADDR_W-1:0]    plane_r;      // H*H, one channel-group plane
  logic [CH_W-1:0]      g_max_r;      // G - 1
  logic [NUM_LANES-1:0] last_mask_r;  // lane mask of the final group

  // Loop counters; oy_o/ox_o are window origins in padded coordinates (o*S)
  logic [PW-1:0]        oy_o, ox_o;
  logic [CH_W-1:0]      g_q;
  logic [K_W-1:0]       ky_q, kx_q;
  logic [ADDR_W-1:0]    grp_base;     // g * plane, tracked incrementally

  logic                 config_err_q;

  // ---------------------------------------------------------------------------
  // Start decode and legality check
  // ---------------------------------------------------------------------------
  logic [PW-1:0] hp_in;
  logic          cfg_bad, start_ok;

  assign hp_in    = PW'(image_size) + (PW'(padding) << 1);
  assign cfg_bad  = (kernel_size == '0) || (number_channel == '0) ||
                    (image_size == '0) || (PW'(kernel_size) > hp_in);
  assign start_ok = (state_q == S_IDLE) && start && !cfg_bad;

  // ---------------------------------------------------------------------------
  // Channel-group geometry, registered during SETUP
  // ---------------------------------------------------------------------------
  int                   g_tot, lanes_last;
  logic [NUM_LANES-1:0] last_mask_d;

  // NOTE: every variable assigned in an always_comb gets a value on every
  // path (here unconditionally), otherwise synthesis infers a latch.
  always_comb begin
    g_tot      = (int'(c_r) + NUM_LANES - 1) / NUM_LANES;
    lanes_last = int'(c_r) - (g_tot - 1) * NUM_LANES;
    for (int i = 0; i < NUM_LANES; i++) begin
      last_mask_d[i] = (i < lanes_last);
    end
  end

  // ---------------------------------------------------------------------------
  // Loop-boundary decode
  // ---------------------------------------------------------------------------
  logic run, fire;
  logic kx_last, ky_last, g_last, ox_last, oy_last, beat_last;

  assign run       = (state_q == S_RUN);
  assign fire      = run && beat.addr_ready;
  assign kx_last   = (kx_q == k_r - K_W'(1));
  assign ky_last   = (ky_q == k_r - K_W'(1));
  assign g_last    = (g_q == g_max_r);
  // The last origin is the one whose next step would push the window past
  // the padded edge; this yields O without a divider.
  assign ox_last   = (ox_o + PW'(s_r) + PW'(k_r)) > hp_r;
  assign oy_last   = (oy_o + PW'(s_r) + PW'(k_r)) > hp_r;
  assign beat_last = kx_last && ky_last && g_last && ox_last && oy_last;

  // ---------------------------------------------------------------------------
  // Address generation
  // ---------------------------------------------------------------------------
  logic [SW-1:0]     iy, ix;
  logic              out_y, out_x, pad;
  logic [ADDR_W-1:0] row_off, addr_inr;

  assign iy = SW'(oy_o) + SW'(ky_q) - SW'(p_r);
  assign ix = SW'(ox_o) + SW'(kx_q) - SW'(p_r);

  // A negative coordinate wraps to a huge unsigned value, so one unsigned
  // compare against H catches both borders.
  assign out_y = (iy >= SW'(h_r));
  assign out_x = (ix >= SW'(h_r));
  assign pad   = out_y || out_x;

  assign row_off  = ADDR_W'(iy) * ADDR_W'(h_r);
  assign addr_inr = grp_base + row_off + ADDR_W'(ix);

  // All beat outputs are decoded from registered state, so they hold still
  // while the consumer stalls.
  assign beat.addr_valid    = run;
  assign beat.address_ifmap = (run && !pad) ? addr_inr : '0;
  assign beat.pad_zero      = run && pad;
  assign beat.channel_en    = run ? (g_last ? last_mask_r : '1) : '0;
  assign beat.PE_start      = run && (g_q == '0) && (ky_q == '0) && (kx_q == '0);
  assign beat.first_channel = run && (g_q == '0);
  assign beat.last_channel  = run && g_last;
  assign beat.pixel_last    = run && g_last && ky_last && kx_last;

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_FIN);
  assign config_err = config_err_q;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_ok) state_d = S_SETUP;
      S_SETUP: state_d = S_RUN;
      S_RUN:   if (fire && beat_last) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      config_err_q <= 1'b0;
      h_r          <= '0;
      c_r          <= '0;
      k_r          <= '0;
      p_r          <= '0;
      s_r          <= '0;
      hp_r         <= '0;
      plane_r      <= '0;
      g_max_r      <= '0;
      last_mask_r  <= '0;
      oy_o         <= '0;
      ox_o         <= '0;
      g_q          <= '0;
      ky_q         <= '0;
      kx_q         <= '0;
      grp_base     <= '0;
    end else begin
      state_q      <= state_d;
      config_err_q <= (state_q == S_IDLE) && start && cfg_bad;

      if (start_ok) begin
        h_r  <= image_size;
        c_r  <= number_channel;
        k_r  <= kernel_size;
        p_r  <= padding;
        s_r  <= (stride == 2'd0) ? 2'd1 : stride;
        hp_r <= hp_in;
      end

      if (state_q == S_SETUP) begin
        plane_r     <= ADDR_W'(h_r) * ADDR_W'(h_r);
        g_max_r     <= CH_W'(g_tot - 1);
        last_mask_r <= last_mask_d;
        oy_o        <= '0;
        ox_o        <= '0;
        g_q         <= '0;
        ky_q        <= '0;
        kx_q        <= '0;
        grp_base    <= '0;
      end

      // Nested odometer: kx innermost, oy outermost.
      if (fire) begin
        if (!kx_last) begin
          kx_q <= kx_q + K_W'(1);
        end else begin
          kx_q <= '0;
          if (!ky_last) begin
            ky_q <= ky_q + K_W'(1);
          end else begin
            ky_q <= '0;
            if (!g_last) begin
              g_q      <= g_q + CH_W'(1);
              grp_base <= grp_base + plane_r;
            end else begin
              g_q      <= '0;
              grp_base <= '0;
              if (!ox_last) begin
                ox_o <= ox_o + PW'(s_r);
              end else begin
                ox_o <= '0;
                oy_o <= oy_last ? '0 : oy_o + PW'(s_r);
              end
            end
          end
        end
      end
    end
  end

`ifdef IFMAP_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Performance counters (saturating)
  // ---------------------------------------------------------------------------
  logic [31:0] beats_q, stalls_q;

  always_ff @(posedge clk) begin
    if (!rst || start_ok) begin
      beats_q  <= '0;
      stalls_q <= '0;
    end else begin
      if (fire && (beats_q != '1)) beats_q <= beats_q + 32'd1;
      if (run && !beat.addr_ready && (stalls_q != '1)) stalls_q <= stalls_q + 32'd1;
    end
  end

  assign perf_beats  = beats_q;
  assign perf_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_ifmap_addr_gen.sv
// -----------------------------------------------------------------------------
// tb_ifmap_addr_gen
//   Directed bench for ifmap_addr_gen: hand-computed spot values plus a
//   nested-loop reference of the full beat sequence for each run.
// -----------------------------------------------------------------------------
module tb_ifmap_addr_gen;

  localparam int ADDR_W    = 16;
  localparam int DIM_W     = 16;
  localparam int CH_W      = 6;
  localparam int NUM_LANES = 32;
  localparam int K_W       = 4;
  localparam int PAD_W     = 2;

  typedef struct packed {
    logic [15:0] addr;
    logic        pad;
    logic [31:0] chen;
    logic        pe;
    logic        fc;
    logic        lc;
    logic        pl;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [DIM_W-1:0] image_size;
  logic [CH_W-1:0]  number_channel;
  logic [K_W-1:0]   kernel_size;
  logic [PAD_W-1:0] padding;
  logic [1:0]       stride;
  logic             busy, done, config_err;
`ifdef IFMAP_PERF_CNT_EN
  logic [31:0]      perf_beats, perf_stalls;
`endif

  ifmap_addr_if #(.ADDR_W(ADDR_W), .NUM_LANES(NUM_LANES)) bus ();

  ifmap_addr_gen #(
    .ADDR_W(ADDR_W), .DIM_W(DIM_W), .CH_W(CH_W),
    .NUM_LANES(NUM_LANES), .K_W(K_W), .PAD_W(PAD_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .image_size     (image_size),
    .number_channel (number_channel),
    .kernel_size    (kernel_size),
    .padding        (padding),
    .stride         (stride),
    .busy           (busy),
    .done           (done),
    .config_err     (config_err),
`ifdef IFMAP_PERF_CNT_EN
    .perf_beats     (perf_beats),
    .perf_stalls    (perf_stalls),
`endif
    .beat           (bus)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_errors = 0;
  beat_t got_q[$];
  beat_t exp_q[$];
  int    stall_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sample_beat(output beat_t b);
    b.addr = bus.address_ifmap;
    b.pad  = bus.pad_zero;
    b.chen = bus.channel_en;
    b.pe   = bus.PE_start;
    b.fc   = bus.first_channel;
    b.lc   = bus.last_channel;
    b.pl   = bus.pixel_last;
  endtask

  // Reference sequence straight from the loop nest and coordinate formulas.
  task automatic build_model(input int h, input int c, input int k, input int p, input int s);
    int    se, o, gn, lanes, iy, ix;
    beat_t b;
    logic [31:0] last_mask;
    exp_q.delete();
    se    = (s == 0) ? 1 : s;
    o     = (h + 2 * p - k) / se + 1;
    gn    = (c + NUM_LANES - 1) / NUM_LANES;
    lanes = c - (gn - 1) * NUM_LANES;
    last_mask = (lanes == 32) ? 32'hFFFF_FFFF : ((32'd1 << lanes) - 32'd1);
    for (int oy = 0; oy < o; oy++)
      for (int ox = 0; ox < o; ox++)
        for (int g = 0; g < gn; g++)
          for (int ky = 0; ky < k; ky++)
            for (int kx = 0; kx < k; kx++) begin
              iy = oy * se + ky - p;
              ix = ox * se + kx - p;
              b.pad  = (iy < 0) || (iy >= h) || (ix < 0) || (ix >= h);
              b.addr = b.pad ? 16'd0 : 16'((g * h * h + iy * h + ix) & 32'hFFFF);
              b.chen = (g < gn - 1) ? 32'hFFFF_FFFF : last_mask;
              b.pe   = (g == 0) && (ky == 0) && (kx == 0);
              b.fc   = (g == 0);
              b.lc   = (g == gn - 1);
              b.pl   = (g == gn - 1) && (ky == k - 1) && (kx == k - 1);
              exp_q.push_back(b);
            end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the first RUN cycle.
  task automatic start_run(input int h, input int c, input int k, input int p, input int s);
    image_size     = DIM_W'(h);
    number_channel = CH_W'(c);
    kernel_size    = K_W'(k);
    padding        = PAD_W'(p);
    stride         = 2'(s);
    start          = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("setup_busy", busy, 1);
    check("setup_valid", bus.addr_valid, 0);
    @(negedge clk);
    check("run_valid", bus.addr_valid, 1);
  endtask

  // Collects accepted beats until n_exp, then checks the FIN/done framing.
  task automatic collect(input int n_exp, input bit rand_ready);
    beat_t cur, held;
    bit    stalled = 0;
    int    beats = 0;
    int    cyc = 0;
    got_q.delete();
    stall_cnt = 0;
    while (beats < n_exp && cyc < 4000) begin
      bus.addr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      sample_beat(cur);
      if (stalled) check("stall_hold", cur, held);
      stalled = 0;
      if (bus.addr_valid) begin
        if (bus.addr_ready) begin
          got_q.push_back(cur);
          beats++;
        end else begin
          stall_cnt++;
          stalled = 1;
          held    = cur;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.addr_ready = 1'b1;
    check("beat_count", beats, n_exp);
    check("fin_done", done, 1);
    check("fin_valid", bus.addr_valid, 0);
    check("fin_busy", busy, 1);
    @(negedge clk);
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
  endtask

  task automatic compare_model(input string name);
    check({name, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s_beat%0d", name, i), (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
    end
  endtask

  initial begin
    int    hand_addr[9];
    int    pe_idx[4];
    int    pl_idx[4];
    int    px_addr[4];
    bit    seen_done;

    hand_addr = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    pe_idx    = '{0, 9, 18, 27};
    pl_idx    = '{8, 17, 26, 35};
    px_addr   = '{0, 2, 10, 12};

    rst            = 1'b0;
    start          = 1'b0;
    image_size     = '0;
    number_channel = '0;
    kernel_size    = '0;
    padding        = '0;
    stride         = '0;
    bus.addr_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outputs",
          {bus.addr_valid, busy, done, config_err, bus.pad_zero, bus.PE_start,
           bus.first_channel, bus.last_channel, bus.pixel_last}, 0);
    check("rst_addr", bus.address_ifmap, 0);
    check("rst_chen", bus.channel_en, 0);
    rst = 1'b1;
    @(negedge clk);

    // Case 1: H=4 C=3 K=3 P=0 S=1, full throughput
    build_model(4, 3, 3, 0, 1);
    start_run(4, 3, 3, 0, 1);
    collect(36, 1'b0);
    compare_model("c1");
    for (int i = 0; i < 9; i++) check($sformatf("c1_addr%0d", i), got_q[i].addr, hand_addr[i]);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("c1_pe%0d", pe_idx[i]), got_q[pe_idx[i]].pe, 1);
      check($sformatf("c1_pl%0d", pl_idx[i]), got_q[pl_idx[i]].pl, 1);
    end
    check("c1_pe1", got_q[1].pe, 0);
    check("c1_chen", got_q[20].chen, 32'h7);
    check("c1_fc_lc", {got_q[13].fc, got_q[13].lc}, 2'b11);

    // Case 2: H=5 C=1 K=3 P=0 S=2
    build_model(5, 1, 3, 0, 2);
    start_run(5, 1, 3, 0, 2);
    collect(36, 1'b0);
    compare_model("c2");
    for (int i = 0; i < 4; i++) check($sformatf("c2_px%0d", i), got_q[9 * i].addr, px_addr[i]);

    // Case 3: H=3 C=1 K=3 P=1 S=1
    build_model(3, 1, 3, 1, 1);
    start_run(3, 1, 3, 1, 1);
    collect(81, 1'b0);
    compare_model("c3");
    check("c3_b0", {got_q[0].pad, got_q[0].addr}, {1'b1, 16'd0});
    check("c3_b4", {got_q[4].pad, got_q[4].addr}, {1'b0, 16'd0});

    // Case 4: H=4 C=40 K=1 P=0 S=1, two channel groups
    build_model(4, 40, 1, 0, 1);
    start_run(4, 40, 1, 0, 1);
    collect(32, 1'b0);
    compare_model("c4");
    check("c4_b0", {got_q[0].addr, got_q[0].chen, got_q[0].fc, got_q[0].lc},
          {16'd0, 32'hFFFF_FFFF, 2'b10});
    check("c4_b1", {got_q[1].addr, got_q[1].chen, got_q[1].fc, got_q[1].lc},
          {16'd16, 32'h0000_00FF, 2'b01});

    // Case 5: case 1 under random backpressure
    build_model(4, 3, 3, 0, 1);
    start_run(4, 3, 3, 0, 1);
    collect(36, 1'b1);
    compare_model("c5");
`ifdef IFMAP_PERF_CNT_EN
    check("perf_beats", perf_beats, 36);
    check("perf_stalls", perf_stalls, stall_cnt);
    repeat (3) @(negedge clk);
    check("perf_hold", perf_beats, 36);
`endif

    // Illegal config: K=6 > H+2P=4
    image_size     = 16'd4;
    number_channel = 6'd1;
    kernel_size    = 4'd6;
    padding        = 2'd0;
    stride         = 2'd1;
    start          = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("cfg_err_pulse", {config_err, busy}, 2'b10);
    @(negedge clk);
    check("cfg_err_clear", {config_err, busy, bus.addr_valid}, 3'b000);

    // Mid-run reset, then a clean rerun of case 1
    start_run(4, 3, 3, 0, 1);
    bus.addr_ready = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_outputs",
          {bus.addr_valid, busy, done, config_err, bus.pad_zero, bus.PE_start,
           bus.first_channel, bus.last_channel, bus.pixel_last}, 0);
    check("abort_addr", {bus.address_ifmap, bus.channel_en}, 0);
    rst = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) seen_done = 1;
    end
    check("abort_no_done", seen_done, 0);

    build_model(4, 3, 3, 0, 1);
    start_run(4, 3, 3, 0, 1);
    collect(36, 1'b0);
    compare_model("c6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ifmap_addr_gen.md
Name: ifmap_addr_gen

Overview:
Parametrised input-feature-map address generator and PE sequencer for the BNN convolution engine. It walks every output pixel, then channel group, then kernel row, then kernel column, and emits one ifmap SRAM address per beat over a valid/ready handshake. Each beat carries a channel-lane mask, a zero-padding flag and PE framing strobes. It sits between the layer sequencer (start/config) and the ifmap SRAM banks / PE array.

Parameters:
ADDR_W, 16, ifmap address width; all address arithmetic is modulo 2^ADDR_W.
DIM_W, 16, width of image_size and internal row/col counters.
CH_W, 6, width of number_channel.
NUM_LANES, 32, channel lanes per beat (one SRAM bank per lane); sets channel_en width.
K_W, 4, width of kernel_size.
PAD_W, 2, width of padding (pad amount in pixels per side).

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  synchronous, active-low reset.
start  in  1  single-cycle request; accepted only in IDLE.
image_size  in  DIM_W  square input dimension H=W; sampled on accepted start.
number_channel  in  CH_W  input channel count C; sampled on start.
kernel_size  in  K_W  square kernel K; sampled on start.
padding  in  PAD_W  pad amount P per side; sampled on start.
stride  in  2  stride S; 0 treated as 1; sampled on start.
addr_ready  in  1  consumer accepts the current beat.
addr_valid  out  1  beat valid.
address_ifmap  out  ADDR_W  SRAM word address.
pad_zero  out  1  beat falls in padding; consumer substitutes zero.
channel_en  out  NUM_LANES  active-lane mask for this beat.
PE_start  out  1  high on the first beat of each output pixel.
first_channel  out  1  current channel group is group 0.
last_channel  out  1  current channel group is the final group.
pixel_last  out  1  high on the final beat of each output pixel.
busy  out  1  high from accepted start until done.
done  out  1  one-cycle pulse after the final beat is accepted.
config_err  out  1  one-cycle pulse when start is rejected for illegal config.

Behaviour:
- Reset (rst=0 at a clock edge): state to IDLE; all outputs 0; counters cleared. Takes effect mid-run; no done is issued for the aborted run.
- FSM: IDLE -> SETUP on start. SETUP -> RUN after exactly 1 cycle. RUN -> FIN when the last beat is accepted. FIN -> IDLE after 1 cycle, with done=1 in FIN.
- Legality check in IDLE: start with K=0, C=0, H=0, or K>H+2P pulses config_err the next cycle and remains in IDLE. busy stays 0.
- start outside IDLE is ignored.
- SETUP: registers plane = H*H (truncated to ADDR_W), G = ceil(C/NUM_LANES) and O = floor((H+2P-K)/S)+1. A divider is not required: O may be derived by stepping the origin by S while origin+K <= H+2P.
- Loop order, outermost first: oy in 0..O-1, ox in 0..O-1, g in 0..G-1, ky in 0..K-1, kx in 0..K-1. Beats per run = O*O*G*K*K.
- Coordinates: iy = oy*S+ky-P and ix = ox*S+kx-P, as signed values.
- Addressing, in-range beat: address_ifmap = g*plane + iy*H + ix and pad_zero=0.
- Addressing, out-of-range beat (iy or ix <0 or >=H): pad_zero=1 and address_ifmap=0.
- channel_en = all ones for g<G-1. For g=G-1 the low (C-(G-1)*NUM_LANES) bits are set.
- first_channel = (g==0). last_channel = (g==G-1). Both are 1 when G=1.
- PE_start = (g==0 && ky==0 && kx==0). pixel_last = (g==G-1 && ky==K-1 && kx==K-1).
- Handshake: addr_valid rises in the first RUN cycle, i.e. 2 cycles after the accepted start. The first beat appears then.
- While addr_valid && !addr_ready, all beat outputs hold stable. The counters advance only on addr_valid && addr_ready.
- The consumer may hold ready low indefinitely. A new beat can be presented every cycle with ready=1, giving full throughput with no bubbles between pixels or groups.
- addr_valid drops in the cycle after the last beat is accepted (the FIN cycle).
- busy = 1 in SETUP, RUN and FIN.

Optional Feature:
Macro: IFMAP_PERF_CNT_EN.
- Defined: adds outputs perf_beats[31:0] (accepted beats) and perf_stalls[31:0] (cycles with addr_valid && !addr_ready). Both counters clear on accepted start and on reset, saturate at all ones, and hold after done.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- H=4, C=3, K=3, P=0, S=1, ready=1 -> O=2 and 36 beats, with channel_en=32'h7 and first/last_channel=1 throughout. The first 9 addresses are 0,1,2,4,5,6,8,9,10. PE_start occurs on beats 0,9,18,27; pixel_last on beats 8,17,26,35; done 1 cycle after beat 35.
- H=5, C=1, K=3, P=0, S=2 -> O=2, and the first beats of pixels 0..3 are at addresses 0,2,10,12.
- H=3, C=1, K=3, P=1, S=1 -> O=3 and 81 beats. Beat 0 has pad_zero=1 and address 0; beat 4 has pad_zero=0 and address 0.
- H=4, C=40, K=1, P=0, S=1 -> G=2 and 32 beats. Pixel 0 gives addresses 0 then 16, with channel_en 32'hFFFFFFFF then 32'h000000FF; first_channel/last_channel read 1/0 then 0/1.
- Random addr_ready backpressure on case 1 -> identical beat sequence, outputs stable during stalls. With IFMAP_PERF_CNT_EN, perf_beats=36 and perf_stalls equals the stall-cycle count.
- K=6, H=4, P=0 -> config_err pulse with busy=0. Separately, rst=0 mid-RUN -> all outputs 0 next cycle and no done pulse. A fresh start then runs case 1 cleanly.
